// File: rtl/fetch_sequencer.sv
// Instruction fetch/sequencing unit: owns PC and IR and runs the 4-phase fetch loop.
// Optional feature macro FETCH_SINGLE_STEP_EN adds a step input and a pause state.
module fetch_sequencer #(
    parameter int                ADDR_W   = 5,
    parameter int                DATA_W   = 8,
    parameter int                OP_W     = 3,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [OP_W-1:0]   opcode,
    output logic [ADDR_W-1:0] operand,
    output logic              ir_valid,
    input  logic              jump,
    input  logic              skip,
    input  logic              Halt,
    input  logic              acc_zero,
    output logic              halted
`ifdef FETCH_SINGLE_STEP_EN
    ,
    input  logic              step
`endif
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_HALT   = 3'd4;
`ifdef FETCH_SINGLE_STEP_EN
    localparam logic [2:0] S_PAUSE  = 3'd5;
`endif

    logic [2:0]        state;
    logic [2:0]        state_next;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_inc;
    logic [DATA_W-1:0] ir;

    assign pc_inc = pc + ADDR_W'(1);

    // Controller outputs only matter in EXEC; Halt wins over jump, jump over skip.
    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:  state_next = S_LOAD;
            S_LOAD:   state_next = S_DECODE;
            S_DECODE: state_next = S_EXEC;
            S_EXEC: begin
                if (Halt)
                    state_next = S_HALT;
                else
`ifdef FETCH_SINGLE_STEP_EN
                    state_next = S_PAUSE;
`else
                    state_next = S_FETCH;
`endif
            end
            S_HALT:   state_next = S_HALT;
`ifdef FETCH_SINGLE_STEP_EN
            S_PAUSE:  state_next = step ? S_FETCH : S_PAUSE;
`endif
            default:  state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_FETCH;
            pc    <= RESET_PC;
            ir    <= '0;
        end else begin
            state <= state_next;
            if (state == S_LOAD) begin
                ir <= mem_rdata;
                pc <= pc_inc;
            end else if (state == S_EXEC && !Halt) begin
                // PC already points past this instruction, so one more increment skips a word.
                if (jump)
                    pc <= ir[ADDR_W-1:0];
                else if (skip && acc_zero)
                    pc <= pc_inc;
            end
        end
    end

    assign mem_addr = pc;
    assign opcode   = ir[DATA_W-1 -: OP_W];
    assign operand  = ir[ADDR_W-1:0];
    assign mem_rd   = (state == S_FETCH);
    assign ir_valid = (state == S_DECODE) || (state == S_EXEC);
    assign halted   = (state == S_HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized self-checking bench for fetch_sequencer with an instruction-level reference model.
// Build with FETCH_SINGLE_STEP_EN defined to exercise the pause/step path as well.
module tb_fetch_sequencer;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;
    localparam int OP_W   = 3;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic [OP_W-1:0]   opcode;
    logic [ADDR_W-1:0] operand;
    logic              ir_valid;
    logic              jump = 1'b0;
    logic              skip = 1'b0;
    logic              Halt = 1'b0;
    logic              acc_zero = 1'b0;
    logic              halted;
`ifdef FETCH_SINGLE_STEP_EN
    logic              step = 1'b0;
`endif

    logic [DATA_W-1:0] mem [DEPTH];

    int assert_count = 0;
    int fail_count   = 0;
    int model_pc     = 0;
    bit model_halted = 0;

    fetch_sequencer #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .OP_W     (OP_W),
        .RESET_PC ('0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_rdata (mem_rdata),
        .opcode    (opcode),
        .operand   (operand),
        .ir_valid  (ir_valid),
        .jump      (jump),
        .skip      (skip),
        .Halt      (Halt),
        .acc_zero  (acc_zero),
        .halted    (halted)
`ifdef FETCH_SINGLE_STEP_EN
        ,
        .step      (step)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous program memory: data appears the cycle after a read strobe.
    always @(posedge clk) begin
        if (mem_rd)
            mem_rdata <= mem[mem_addr];
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assert_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic randomCtrl();
        jump     = 1'($urandom_range(0, 1));
        skip     = 1'($urandom_range(0, 1));
        Halt     = 1'($urandom_range(0, 1));
        acc_zero = 1'($urandom_range(0, 1));
    endtask

    // Asserts reset mid-cycle, checks the reset values at once, releases on a falling edge.
    task automatic resetDut();
        rst = 1'b1;
        #1;
        checkOutput("rst_addr", 32'(mem_addr), 32'd0);
        checkOutput("rst_opcode", 32'(opcode), 32'd0);
        checkOutput("rst_operand", 32'(operand), 32'd0);
        checkOutput("rst_rd", 32'(mem_rd), 32'd1);
        checkOutput("rst_irv", 32'(ir_valid), 32'd0);
        checkOutput("rst_halted", 32'(halted), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_pc     = 0;
        model_halted = 0;
    endtask

    // Runs one whole instruction starting in its fetch cycle; j/s/h/az are the EXEC-time controller values.
    task automatic applyStimulus(input logic j, input logic s, input logic h, input logic az);
        int                pc0;
        int                pc_inc;
        logic [DATA_W-1:0] word;
        pc0    = model_pc;
        pc_inc = (pc0 + 1) % DEPTH;
        word   = mem[pc0];

        checkOutput("fetch_addr", 32'(mem_addr), 32'(pc0));
        checkOutput("fetch_rd", 32'(mem_rd), 32'd1);
        checkOutput("fetch_irv", 32'(ir_valid), 32'd0);
        randomCtrl();
        @(negedge clk);
        checkOutput("load_rd", 32'(mem_rd), 32'd0);
        checkOutput("load_irv", 32'(ir_valid), 32'd0);
        randomCtrl();
        @(negedge clk);
        checkOutput("dec_opcode", 32'(opcode), 32'(word[DATA_W-1 -: OP_W]));
        checkOutput("dec_operand", 32'(operand), 32'(word[ADDR_W-1:0]));
        checkOutput("dec_irv", 32'(ir_valid), 32'd1);
        checkOutput("dec_addr", 32'(mem_addr), 32'(pc_inc));
        randomCtrl();
        @(negedge clk);
        checkOutput("exec_opcode", 32'(opcode), 32'(word[DATA_W-1 -: OP_W]));
        checkOutput("exec_irv", 32'(ir_valid), 32'd1);
        jump     = j;
        skip     = s;
        Halt     = h;
        acc_zero = az;
        @(negedge clk);
        randomCtrl();

        if (h) begin
            model_halted = 1;
            model_pc     = pc_inc;
        end else if (j)
            model_pc = int'(word[ADDR_W-1:0]);
        else if (s && az)
            model_pc = (pc0 + 2) % DEPTH;
        else
            model_pc = pc_inc;

        if (model_halted) begin
            checkOutput("halt_flag", 32'(halted), 32'd1);
            checkOutput("halt_rd", 32'(mem_rd), 32'd0);
            checkOutput("halt_irv", 32'(ir_valid), 32'd0);
            checkOutput("halt_addr", 32'(mem_addr), 32'(model_pc));
        end else begin
            checkOutput("next_halted", 32'(halted), 32'd0);
`ifdef FETCH_SINGLE_STEP_EN
            for (int k = 0; k < int'($urandom_range(1, 4)); k++) begin
                checkOutput("pause_rd", 32'(mem_rd), 32'd0);
                checkOutput("pause_irv", 32'(ir_valid), 32'd0);
                checkOutput("pause_addr", 32'(mem_addr), 32'(model_pc));
                randomCtrl();
                @(negedge clk);
            end
            checkOutput("pause_hold_rd", 32'(mem_rd), 32'd0);
            step = 1'b1;
            @(negedge clk);
            step = 1'b0;
`endif
        end
    endtask

    task automatic holdHalted(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            randomCtrl();
            @(negedge clk);
            checkOutput("hold_halted", 32'(halted), 32'd1);
            checkOutput("hold_rd", 32'(mem_rd), 32'd0);
            checkOutput("hold_addr", 32'(mem_addr), 32'(model_pc));
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++)
            mem[i] = 8'h40;
        mem[0]    = 8'h40;
        mem[1]    = 8'h41;
        mem[2]    = 8'h42;
        mem[3]    = 8'hFA;
        mem[5'h1A] = 8'hE5;
        mem[5]    = 8'h20;
        mem[7]    = 8'hE5;
        mem[6]    = 8'hFE;
        mem[30]   = 8'h20;

        #2;
        resetDut();

        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        checkOutput("jmp_target", 32'(model_pc), 32'h1A);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 1, 0, 1);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 1, 0, 1);
        applyStimulus(0, 0, 0, 0);

        // Abort in the middle of the load cycle: PC is nonzero and IR holds a nonzero word.
        checkOutput("pre_abort_addr", 32'(mem_addr), 32'd1);
        @(negedge clk);
        #2;
        resetDut();

        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(1, 0, 1, 0);
        holdHalted(100);
        #3;
        resetDut();

        mem[0]  = 8'hFF;
        mem[31] = 8'h40;
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        mem[0]  = 8'hE0;
        applyStimulus(1, 0, 0, 0);

        for (int i = 0; i < DEPTH; i++)
            mem[i] = 8'($urandom);
        for (int n = 0; n < 300; n++) begin
            applyStimulus(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0),
                          1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 1)));
            if (model_halted) begin
                holdHalted(5);
                #3;
                resetDut();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
